// File: rtl/tlb_op_ctrl.sv
// ============================================================================
// Module   : tlb_op_ctrl
// Purpose  : Sequences CP0 TLBP/TLBR/TLBWI/TLBWR against the TLB ports and
//            maintains the CP0 Random register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tlb_op_ctrl #(
    parameter  int TLBNUM = 16,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          op_valid,
    input  logic [1:0]    op_type,
    output logic          op_ready,
    input  logic [31:0]   cp0_entryhi,
    input  logic [31:0]   cp0_pagemask,
    input  logic [31:0]   cp0_entrylo0,
    input  logic [31:0]   cp0_entrylo1,
    input  logic [IW-1:0] cp0_index,
    input  logic [IW-1:0] cp0_wired,
    input  logic          cp0_wired_we,
    output logic [18:0]   s_vpn2,
    output logic [7:0]    s_asid,
    input  logic          s_found,
    input  logic [IW-1:0] s_index,
    output logic [IW-1:0] r_index,
    input  logic [89:0]   r_entry,
    output logic          tlb_we,
    output logic [IW-1:0] w_index,
    output logic [89:0]   w_entry,
    output logic [IW-1:0] cp0_random,
    output logic          index_we,
    output logic [31:0]   index_wdata,
    output logic          tlbr_we,
    output logic [31:0]   entryhi_wdata,
    output logic [31:0]   entrylo0_wdata,
    output logic [31:0]   entrylo1_wdata,
    output logic [31:0]   pagemask_wdata,
    output logic          done,
    output logic          refetch_req
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [1:0]    c_op_tlbp   = 2'd0;
    localparam logic [1:0]    c_op_tlbr   = 2'd1;
    localparam logic [1:0]    c_op_tlbwi  = 2'd2;
    localparam logic [1:0]    c_op_tlbwr  = 2'd3;
    localparam logic [IW-1:0] c_rand_max  = IW'(TLBNUM - 1);

    state_e        state_q, state_d;
    logic [1:0]    op_q;
    logic [18:0]   vpn2_q;
    logic [7:0]    asid_q;
    logic [11:0]   mask_q;
    logic [25:0]   lo0_q, lo1_q;
    logic [IW-1:0] index_q, rand_cap_q;
    logic [IW-1:0] random_q, random_d;
    logic [31:0]   index_wdata_q, entryhi_wdata_q, entrylo0_wdata_q;
    logic [31:0]   entrylo1_wdata_q, pagemask_wdata_q;
    logic          accept;
    logic [89:0]   entry_wr;
    logic          unused_bits;

    assign accept   = (state_q == S_IDLE) && op_valid;
    assign op_ready = (state_q == S_IDLE);

    // lo*_q[25:1] is {pfn, c, d, v}; the entry keeps a single G = G0 & G1
    assign entry_wr = {mask_q, vpn2_q, asid_q, lo0_q[0] & lo1_q[0],
                       lo0_q[25:1], lo1_q[25:1]};

    assign cp0_random     = random_q;
    assign index_wdata    = index_wdata_q;
    assign entryhi_wdata  = entryhi_wdata_q;
    assign entrylo0_wdata = entrylo0_wdata_q;
    assign entrylo1_wdata = entrylo1_wdata_q;
    assign pagemask_wdata = pagemask_wdata_q;

    assign unused_bits = ^{cp0_entryhi[12:8], cp0_pagemask[31:25], cp0_pagemask[12:0],
                           cp0_entrylo0[31:26], cp0_entrylo1[31:26]};

    // Random reloads to the top once it reaches or falls below Wired
    always_comb begin
        random_d = random_q - IW'(1);
        if (cp0_wired_we || (random_q <= cp0_wired)) begin
            random_d = c_rand_max;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_vpn2      = '0;
        s_asid      = '0;
        r_index     = '0;
        tlb_we      = 1'b0;
        w_index     = '0;
        w_entry     = '0;
        done        = 1'b0;
        refetch_req = 1'b0;
        index_we    = 1'b0;
        tlbr_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op_valid) state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_DONE;
                case (op_q)
                    c_op_tlbp: begin
                        s_vpn2 = vpn2_q;
                        s_asid = asid_q;
                    end
                    c_op_tlbr: r_index = index_q;
                    c_op_tlbwi: begin
                        tlb_we  = 1'b1;
                        w_index = index_q;
                        w_entry = entry_wr;
                    end
                    default: begin
                        tlb_we  = 1'b1;
                        w_index = rand_cap_q;
                        w_entry = entry_wr;
                    end
                endcase
            end
            S_DONE: begin
                state_d     = S_IDLE;
                done        = 1'b1;
                refetch_req = 1'b1;
                index_we    = (op_q == c_op_tlbp);
                tlbr_we     = (op_q == c_op_tlbr);
            end
            default: state_d = S_IDLE;
        endcase
        // An operation cut short by reset must not touch the TLB or CP0
        if (reset) begin
            tlb_we      = 1'b0;
            done        = 1'b0;
            refetch_req = 1'b0;
            index_we    = 1'b0;
            tlbr_we     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            random_q         <= c_rand_max;
            op_q             <= c_op_tlbp;
            vpn2_q           <= '0;
            asid_q           <= '0;
            mask_q           <= '0;
            lo0_q            <= '0;
            lo1_q            <= '0;
            index_q          <= '0;
            rand_cap_q       <= '0;
            index_wdata_q    <= '0;
            entryhi_wdata_q  <= '0;
            entrylo0_wdata_q <= '0;
            entrylo1_wdata_q <= '0;
            pagemask_wdata_q <= '0;
        end else begin
            state_q  <= state_d;
            random_q <= random_d;
            if (accept) begin
                op_q       <= op_type;
                vpn2_q     <= cp0_entryhi[31:13];
                asid_q     <= cp0_entryhi[7:0];
                mask_q     <= cp0_pagemask[24:13];
                lo0_q      <= cp0_entrylo0[25:0];
                lo1_q      <= cp0_entrylo1[25:0];
                index_q    <= cp0_index;
                rand_cap_q <= random_q;
            end
            if (state_q == S_EXEC && op_q == c_op_tlbp) begin
                index_wdata_q <= s_found ? {{(32-IW){1'b0}}, s_index} : 32'h8000_0000;
            end
            if (state_q == S_EXEC && op_q == c_op_tlbr) begin
                entryhi_wdata_q  <= {r_entry[77:59], 5'b0, r_entry[58:51]};
                pagemask_wdata_q <= {7'b0, r_entry[89:78], 13'b0};
                entrylo0_wdata_q <= {6'b0, r_entry[49:25], r_entry[50]};
                entrylo1_wdata_q <= {6'b0, r_entry[24:0], r_entry[50]};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tlb_op_ctrl.sv
// ============================================================================
// Module   : tb_tlb_op_ctrl
// Purpose  : Self-checking bench for tlb_op_ctrl with a behavioural TLB and a
//            CP0-level shadow model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tlb_op_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, op_valid, op_ready;
    logic [1:0]  op_type;
    logic [31:0] cp0_entryhi, cp0_pagemask, cp0_entrylo0, cp0_entrylo1;
    logic [3:0]  cp0_index, cp0_wired;
    logic        cp0_wired_we;
    logic [18:0] s_vpn2;
    logic [7:0]  s_asid;
    logic        s_found;
    logic [3:0]  s_index, r_index, w_index, cp0_random;
    logic [89:0] r_entry, w_entry;
    logic        tlb_we, index_we, tlbr_we, done, refetch_req;
    logic [31:0] index_wdata, entryhi_wdata, entrylo0_wdata, entrylo1_wdata, pagemask_wdata;

    tlb_op_ctrl #(.TLBNUM(16)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_type(op_type), .op_ready(op_ready),
        .cp0_entryhi(cp0_entryhi), .cp0_pagemask(cp0_pagemask),
        .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
        .cp0_index(cp0_index), .cp0_wired(cp0_wired), .cp0_wired_we(cp0_wired_we),
        .s_vpn2(s_vpn2), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
        .r_index(r_index), .r_entry(r_entry), .tlb_we(tlb_we), .w_index(w_index),
        .w_entry(w_entry), .cp0_random(cp0_random), .index_we(index_we),
        .index_wdata(index_wdata), .tlbr_we(tlbr_we), .entryhi_wdata(entryhi_wdata),
        .entrylo0_wdata(entrylo0_wdata), .entrylo1_wdata(entrylo1_wdata),
        .pagemask_wdata(pagemask_wdata), .done(done), .refetch_req(refetch_req)
    );

    // Behavioural TLB the controller talks to
    logic [89:0] tlb_mem [16];
    logic        mem_clear;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) tlb_mem[i] <= '0;
        end else if (tlb_we) begin
            tlb_mem[w_index] <= w_entry;
        end
    end

    assign r_entry = tlb_mem[r_index];

    always_comb begin
        s_found = 1'b0;
        s_index = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if ((((tlb_mem[i][77:59] ^ s_vpn2) & ~{7'b0, tlb_mem[i][89:78]}) == 19'd0) &&
                (tlb_mem[i][50] || (tlb_mem[i][58:51] == s_asid))) begin
                s_found = 1'b1;
                s_index = 4'(i);
            end
        end
    end

    // Expected Random register value
    logic [3:0] exp_rand;
    always @(posedge clk) begin
        if (reset || cp0_wired_we || exp_rand <= cp0_wired) exp_rand <= 4'd15;
        else                                                exp_rand <= exp_rand - 4'd1;
    end

    // CP0-level shadow of what software has written into each TLB slot
    logic [31:0] sh_eh [16];
    logic [31:0] sh_pm [16];
    logic [31:0] sh_l0 [16];
    logic [31:0] sh_l1 [16];
    logic [31:0] e_iw, e_eh, e_l0, e_l1, e_pm;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [89:0] got, input logic [89:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        chk("random", cp0_random, exp_rand);
    endtask

    function automatic logic [89:0] pack(input logic [31:0] eh, pm, l0, l1);
        return {pm[24:13], eh[31:13], eh[7:0], l0[0] & l1[0],
                l0[25:6], l0[5:3], l0[2], l0[1], l1[25:6], l1[5:3], l1[2], l1[1]};
    endfunction

    function automatic logic sh_search(input logic [18:0] vpn, input logic [7:0] asid,
                                       output logic [3:0] idx);
        logic hit;
        hit = 1'b0;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if ((((sh_eh[i][31:13] ^ vpn) & ~{7'b0, sh_pm[i][24:13]}) == 19'd0) &&
                ((sh_l0[i][0] & sh_l1[i][0]) || sh_eh[i][7:0] == asid)) begin
                hit = 1'b1;
                idx = 4'(i);
            end
        end
        return hit;
    endfunction

    task automatic run_op(input logic [1:0] t, input logic [31:0] eh, pm, l0, l1,
                          input logic [3:0] idx);
        logic [3:0] cap, wi, hidx;
        logic       hit, g;
        chk("idle_ready", op_ready, 1'b1);
        cap = exp_rand;
        wi  = (t == 2'd2) ? idx : cap;
        if (t == 2'd0) begin
            hit  = sh_search(eh[31:13], eh[7:0], hidx);
            e_iw = hit ? {28'd0, hidx} : 32'h8000_0000;
        end
        if (t == 2'd1) begin
            g    = sh_l0[idx][0] & sh_l1[idx][0];
            e_eh = {sh_eh[idx][31:13], 5'b0, sh_eh[idx][7:0]};
            e_pm = sh_pm[idx] & 32'h01FF_E000;
            e_l0 = {6'b0, sh_l0[idx][25:1], g};
            e_l1 = {6'b0, sh_l1[idx][25:1], g};
        end
        op_valid = 1'b1; op_type = t; cp0_entryhi = eh; cp0_pagemask = pm;
        cp0_entrylo0 = l0; cp0_entrylo1 = l1; cp0_index = idx;
        cyc();
        op_valid = 1'b0; op_type = 2'($urandom);
        cp0_entryhi = $urandom; cp0_pagemask = $urandom;
        cp0_entrylo0 = $urandom; cp0_entrylo1 = $urandom; cp0_index = 4'($urandom);
        chk("exec_ready", op_ready, 1'b0);
        chk("exec_tlb_we", tlb_we, t[1]);
        chk("exec_w_index", w_index, t[1] ? wi : 4'd0);
        chk("exec_w_entry", w_entry, t[1] ? pack(eh, pm, l0, l1) : 90'd0);
        chk("exec_s_vpn2", s_vpn2, (t == 2'd0) ? eh[31:13] : 19'd0);
        chk("exec_s_asid", s_asid, (t == 2'd0) ? eh[7:0] : 8'd0);
        chk("exec_r_index", r_index, (t == 2'd1) ? idx : 4'd0);
        chk("exec_done", done, 1'b0);
        cyc();
        chk("done_pulse", done, 1'b1);
        chk("done_refetch", refetch_req, 1'b1);
        chk("done_index_we", index_we, t == 2'd0);
        chk("done_tlbr_we", tlbr_we, t == 2'd1);
        chk("done_tlb_we", tlb_we, 1'b0);
        chk("done_ready", op_ready, 1'b0);
        chk("done_w_entry", w_entry, 90'd0);
        chk("done_s_vpn2", s_vpn2, 19'd0);
        chk("index_wdata", index_wdata, e_iw);
        chk("entryhi_wdata", entryhi_wdata, e_eh);
        chk("entrylo0_wdata", entrylo0_wdata, e_l0);
        chk("entrylo1_wdata", entrylo1_wdata, e_l1);
        chk("pagemask_wdata", pagemask_wdata, e_pm);
        if (t[1]) begin
            sh_eh[wi] = eh; sh_pm[wi] = pm; sh_l0[wi] = l0; sh_l1[wi] = l1;
        end
        cyc();
        chk("idle_done", done, 1'b0);
        chk("idle_refetch", refetch_req, 1'b0);
        chk("idle_index_we", index_we, 1'b0);
        chk("idle_tlbr_we", tlbr_we, 1'b0);
    endtask

    task automatic wait_rand(input logic [3:0] v);
        for (int k = 0; k < 40; k++) begin
            if (cp0_random == v) break;
            cyc();
        end
        chk("wait_random", cp0_random, v);
    endtask

    task automatic clear_exp();
        e_iw = '0; e_eh = '0; e_l0 = '0; e_l1 = '0; e_pm = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  t;
        logic [31:0] eh, pm;
        logic [3:0]  hidx;
        logic        hit;
        reset = 1'b1; mem_clear = 1'b1; op_valid = 1'b0; op_type = 2'd0;
        cp0_entryhi = '0; cp0_pagemask = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0;
        cp0_index = '0; cp0_wired = '0; cp0_wired_we = 1'b0;
        clear_exp();
        for (int i = 0; i < 16; i++) begin
            sh_eh[i] = '0; sh_pm[i] = '0; sh_l0[i] = '0; sh_l1[i] = '0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0; mem_clear = 1'b0;

        chk("rst_ready", op_ready, 1'b1);
        chk("rst_random", cp0_random, 4'd15);
        chk("rst_done", done, 1'b0);
        chk("rst_tlb_we", tlb_we, 1'b0);
        chk("rst_index_wdata", index_wdata, 32'd0);

        // Directed write, probe hit/miss and readback
        run_op(2'd2, 32'h0040_2012, 32'h0, 32'h0000_0047, 32'h0000_0087, 4'd5);
        chk("tlbwi_vpn2", tlb_mem[5][77:59], 19'h00201);
        chk("tlbwi_g", tlb_mem[5][50], 1'b1);
        run_op(2'd0, 32'h0040_2012, 32'h0, 32'h0, 32'h0, 4'd0);
        chk("tlbp_hit", index_wdata, 32'h0000_0005);
        run_op(2'd0, 32'hFFFF_E013, 32'h0, 32'h0, 32'h0, 4'd0);
        chk("tlbp_miss", index_wdata, 32'h8000_0000);
        run_op(2'd1, 32'h0, 32'h0, 32'h0, 32'h0, 4'd5);
        chk("tlbr_eh", entryhi_wdata, 32'h0040_2012);
        chk("tlbr_lo0", entrylo0_wdata, 32'h0000_0047);
        chk("tlbr_lo1", entrylo1_wdata, 32'h0000_0087);
        chk("tlbr_pm", pagemask_wdata, 32'h0);

        // Random sequence with Wired = 3 straight out of reset
        cp0_wired = 4'd3; reset = 1'b1;
        cyc();
        reset = 1'b0;
        clear_exp();
        for (int i = 0; i < 14; i++) begin
            chk("rand_seq", cp0_random, (i <= 12) ? 4'(15 - i) : 4'd15);
            cyc();
        end
        wait_rand(4'd12);
        cp0_wired = 4'd8; cp0_wired_we = 1'b1;
        cyc();
        cp0_wired_we = 1'b0;
        chk("wired_we_reload", cp0_random, 4'd15);
        wait_rand(4'd9);
        run_op(2'd3, 32'h0123_4000, 32'h0, 32'h0000_1003, 32'h0000_2005, 4'd0);
        chk("tlbwr_slot9", tlb_mem[9][77:59], 19'h0091A);

        // Wired at the top pins Random
        cp0_wired = 4'd15;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("rand_pinned", cp0_random, 4'd15);
            cyc();
        end
        cp0_wired = 4'd0;

        // Back-to-back issue with op_valid held high
        op_type = 2'd0; cp0_entryhi = sh_eh[5]; op_valid = 1'b1;
        hit  = sh_search(sh_eh[5][31:13], sh_eh[5][7:0], hidx);
        e_iw = hit ? {28'd0, hidx} : 32'h8000_0000;
        for (int i = 0; i < 9; i++) begin
            chk("b2b_ready", op_ready, (i % 3) == 0);
            chk("b2b_done", done, (i % 3) == 2);
            cyc();
        end
        op_valid = 1'b0;
        chk("b2b_index_wdata", index_wdata, e_iw);

        // Reset during the EXEC cycle of a TLBWI
        op_valid = 1'b1; op_type = 2'd2; cp0_entryhi = 32'hABCD_E055;
        cp0_pagemask = 32'h0; cp0_entrylo0 = 32'h0000_0FFF; cp0_entrylo1 = 32'h0000_0FFF;
        cp0_index = 4'd5;
        cyc();
        op_valid = 1'b0; reset = 1'b1;
        #1;
        chk("abort_tlb_we", tlb_we, 1'b0);
        cyc();
        chk("abort_done", done, 1'b0);
        chk("abort_refetch", refetch_req, 1'b0);
        chk("abort_ready", op_ready, 1'b1);
        chk("abort_index_wdata", index_wdata, 32'd0);
        reset = 1'b0;
        clear_exp();
        run_op(2'd1, 32'h0, 32'h0, 32'h0, 32'h0, 4'd5);
        chk("abort_keep_eh", entryhi_wdata, 32'h0040_2012);
        chk("abort_keep_lo0", entrylo0_wdata, 32'h0000_0047);

        // Randomized operations against the shadow model
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                cp0_wired = 4'($urandom_range(0, 15));
                cp0_wired_we = 1'b1;
                cyc();
                cp0_wired_we = 1'b0;
            end
            t  = 2'($urandom_range(0, 3));
            eh = $urandom;
            if (t == 2'd0 && $urandom_range(0, 1) == 1) eh = sh_eh[$urandom_range(0, 15)];
            pm = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h01FF_E000) : 32'h0;
            run_op(t, eh, pm, $urandom, $urandom, 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
- Sequences the CP0 TLB instructions TLBP, TLBR, TLBWI and TLBWR against the 16-entry dual-page TLB.
- Sits between the writeback stage and the TLB. It owns the TLB write port, the read port and search port 2 (the probe port).
- Maintains the CP0 Random register and returns the TLBP/TLBR results to CP0 as one-cycle write strobes.
- Requests a pipeline refetch when an operation completes.

Parameters:
- TLBNUM, 16, number of TLB entries. IW = $clog2(TLBNUM) = 4.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- op_valid  in  1  TLB instruction request from writeback.
- op_type  in  2  operation: 0 = TLBP, 1 = TLBR, 2 = TLBWI, 3 = TLBWR.
- op_ready  out  1  controller idle; request is accepted when op_valid && op_ready.
- cp0_entryhi  in  32  VPN2 in [31:13], ASID in [7:0].
- cp0_pagemask  in  32  mask in [24:13].
- cp0_entrylo0  in  32  PFN [25:6], C [5:3], D [2], V [1], G [0].
- cp0_entrylo1  in  32  same layout as cp0_entrylo0, for the odd page.
- cp0_index  in  IW  TLBWI target index.
- cp0_wired  in  IW  Wired register value.
- cp0_wired_we  in  1  Wired is being written this cycle.
- s_vpn2  out  19  probe VPN2.
- s_asid  out  8  probe ASID.
- s_found  in  1  probe hit.
- s_index  in  IW  probe hit index.
- r_index  out  IW  TLB read index.
- r_entry  in  90  read entry, packed {mask12, vpn2 19, asid8, g, pfn0 20, c0 3, d0, v0, pfn1 20, c1 3, d1, v1}.
- tlb_we  out  1  TLB write enable.
- w_index  out  IW  TLB write index.
- w_entry  out  90  write entry, same packing as r_entry.
- cp0_random  out  IW  Random register value.
- index_we  out  1  write strobe for the CP0 Index register.
- index_wdata  out  32  Index write data.
- tlbr_we  out  1  write strobe for EntryHi, EntryLo0, EntryLo1 and PageMask together.
- entryhi_wdata  out  32  EntryHi write data.
- entrylo0_wdata  out  32  EntryLo0 write data.
- entrylo1_wdata  out  32  EntryLo1 write data.
- pagemask_wdata  out  32  PageMask write data.
- done  out  1  one-cycle completion pulse.
- refetch_req  out  1  one-cycle pulse, coincident with done.

Behaviour:
- FSM states: IDLE, EXEC, DONE. op_ready = (state == IDLE).
- Accept in IDLE (cycle 0): capture op_type, all cp0_* inputs, and cp0_random. Then go to EXEC. op_valid is ignored outside IDLE.
- EXEC (cycle 1), operation-specific actions:
  - TLBP: drive s_vpn2 and s_asid from the captured EntryHi and register s_found/s_index.
  - TLBR: drive r_index from the captured Index and register r_entry.
  - TLBWI: tlb_we = 1, w_index = captured Index.
  - TLBWR: tlb_we = 1, w_index = captured Random.
  - All cases: go to DONE.
- DONE (cycle 2): done = 1 and refetch_req = 1. Then:
  - TLBP: index_we = 1.
  - TLBR: tlbr_we = 1.
  - All cases: go to IDLE.
- Latency: accept to done is 2 cycles. Back-to-back issue is possible every 3 cycles.
- w_entry fields:
  - mask = PageMask[24:13]; vpn2 = EntryHi[31:13]; asid = EntryHi[7:0].
  - g = EntryLo0[0] & EntryLo1[0].
  - pfn, c, d, v taken from the matching EntryLo fields.
  - The TLB applies the mask itself; w_entry is unmasked.
- index_wdata:
  - hit: {1'b0, 27'b0, s_index}.
  - miss: 32'h8000_0000 (P bit set).
- TLBR write data:
  - entryhi_wdata = {vpn2, 5'b0, asid}.
  - pagemask_wdata = {7'b0, mask, 13'b0}.
  - entrylo0_wdata = {6'b0, pfn0, c0, d0, v0, g}; entrylo1_wdata uses the same layout with the odd-page fields.
- Output defaults: tlb_we, index_we, tlbr_we, done and refetch_req are 0 outside their stated cycles. s_*, r_index and w_* are 0 except in EXEC. All wdata outputs hold their last value.
- Random register:
  - Reset value TLBNUM-1; decrements every cycle.
  - If Random == cp0_wired, next value is TLBNUM-1.
  - If Random < cp0_wired, next value is TLBNUM-1.
  - If cp0_wired_we = 1, next value is TLBNUM-1.
  - If cp0_wired == TLBNUM-1, Random stays at TLBNUM-1.
  - TLBWR uses the value captured at accept, not the value in EXEC.
- Reset, at any point including mid-operation: state = IDLE, op_ready = 1, all strobes 0, wdata outputs 0, Random = TLBNUM-1. An aborted operation produces no TLB or CP0 write.
- Multiple simultaneous probe hits are a software error; the result is whatever index the TLB reports.

Test Plan:
- Reset, then TLBWI with Index = 5, EntryHi = 32'h0040_2012, PageMask = 0, EntryLo0 = 32'h0000_0047, EntryLo1 = 32'h0000_0087 -> tlb_we only in cycle 1, w_index = 5, w_entry.vpn2 = 19'h00201, g = 1; done in cycle 2; index_we = 0 and tlbr_we = 0.
- TLBP with the EntryHi above after that write -> index_we in cycle 2 with index_wdata = 32'h0000_0005. TLBP with ASID 0x13 and VPN2 0x7FFFF -> index_wdata = 32'h8000_0000.
- TLBR with Index = 5 -> tlbr_we in cycle 2; entryhi_wdata = 32'h0040_2012, entrylo0_wdata = 32'h0000_0047, entrylo1_wdata = 32'h0000_0087, pagemask_wdata = 0.
- Random with wired = 3 from reset -> sequence 15, 14, …, 3, 15; writing wired = 8 mid-sequence -> Random = 15 next cycle; TLBWR accepted while Random = 9 -> w_index = 9.
- op_valid held high continuously -> accepts exactly every 3 cycles, op_ready low in EXEC and DONE.
- reset asserted in the EXEC cycle of a TLBWI -> no done, no refetch_req, and the TLB entry is unchanged on a later TLBR.
